// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge: turns one single-beat MMU memory request into a single
// AXI4-Lite master transaction and returns a one-cycle completion pulse.
// Only one transaction is outstanding at a time.
module mem_axi_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rstn,
   // MMU request side
   input  logic                      request_enable,
   input  logic                      req_mode,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
   // MMU response side
   output logic                      response_enable,
   output logic [DATA_WIDTH-1:0]     resp_data,
   output logic                      bus_error,
   // AXI write-address channel
   output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   // AXI write-data channel
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   // AXI write-response channel
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   // AXI read-address channel
   output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   // AXI read-data channel
   input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR      = 3'd3,
      S_WR_RESP = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
   logic                    bus_error_q, bus_error_d;
   logic                    response_enable_q, response_enable_d;

   logic                    aw_hs_s;
   logic                    w_hs_s;

   // Handshake strobes for the two independent write channels.
   always_comb begin
      aw_hs_s = awvalid_q & m_axi_awready;
      w_hs_s  = wvalid_q & m_axi_wready;
   end

   // Next-state and registered-output computation for the transaction FSM.
   always_comb begin
      state_d           = state_q;
      addr_d            = addr_q;
      wdata_d           = wdata_q;
      wstrb_d           = wstrb_q;
      arvalid_d         = arvalid_q;
      rready_d          = rready_q;
      awvalid_d         = awvalid_q;
      wvalid_d          = wvalid_q;
      bready_d          = bready_q;
      aw_done_d         = aw_done_q;
      w_done_d          = w_done_q;
      resp_data_d       = resp_data_q;
      // completion pulse and error flag are only ever high for one cycle
      bus_error_d       = 1'b0;
      response_enable_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (request_enable) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wstrb_d = req_wstrb;
               if (req_mode) begin
                  state_d   = S_WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = S_RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_RD_ADDR: begin
            if (arvalid_q && m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_DATA;
            end else begin
               state_d = S_RD_ADDR;
            end
         end

         S_RD_DATA: begin
            if (m_axi_rvalid && rready_q) begin
               resp_data_d       = m_axi_rdata;
               bus_error_d       = (m_axi_rresp != 2'b00);
               rready_d          = 1'b0;
               response_enable_d = 1'b1;
               state_d           = S_DONE;
            end else begin
               state_d = S_RD_DATA;
            end
         end

         S_WR: begin
            // each channel drops its valid after its own handshake
            if (aw_hs_s) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end else begin
               aw_done_d = aw_done_q;
            end
            if (w_hs_s) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end else begin
               w_done_d = w_done_q;
            end
            // both channels finished, possibly on this very edge
            if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
               bready_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_WR_RESP;
            end else begin
               state_d = S_WR;
            end
         end

         S_WR_RESP: begin
            if (m_axi_bvalid && bready_q) begin
               resp_data_d       = {DATA_WIDTH{1'b0}};
               bus_error_d       = (m_axi_bresp != 2'b00);
               bready_d          = 1'b0;
               response_enable_d = 1'b1;
               state_d           = S_DONE;
            end else begin
               state_d = S_WR_RESP;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d   = S_IDLE;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops every valid/ready immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q           <= S_IDLE;
         addr_q            <= {ADDR_WIDTH{1'b0}};
         wdata_q           <= {DATA_WIDTH{1'b0}};
         wstrb_q           <= {STRB_WIDTH{1'b0}};
         arvalid_q         <= 1'b0;
         rready_q          <= 1'b0;
         awvalid_q         <= 1'b0;
         wvalid_q          <= 1'b0;
         bready_q          <= 1'b0;
         aw_done_q         <= 1'b0;
         w_done_q          <= 1'b0;
         resp_data_q       <= {DATA_WIDTH{1'b0}};
         bus_error_q       <= 1'b0;
         response_enable_q <= 1'b0;
      end else begin
         state_q           <= state_d;
         addr_q            <= addr_d;
         wdata_q           <= wdata_d;
         wstrb_q           <= wstrb_d;
         arvalid_q         <= arvalid_d;
         rready_q          <= rready_d;
         awvalid_q         <= awvalid_d;
         wvalid_q          <= wvalid_d;
         bready_q          <= bready_d;
         aw_done_q         <= aw_done_d;
         w_done_q          <= w_done_d;
         resp_data_q       <= resp_data_d;
         bus_error_q       <= bus_error_d;
         response_enable_q <= response_enable_d;
      end
   end

   // Outputs come straight from registers; protection bits are fixed.
   always_comb begin
      response_enable = response_enable_q;
      resp_data       = resp_data_q;
      bus_error       = bus_error_q;
      m_axi_awaddr    = addr_q;
      m_axi_awprot    = 3'b000;
      m_axi_awvalid   = awvalid_q;
      m_axi_wdata     = wdata_q;
      m_axi_wstrb     = wstrb_q;
      m_axi_wvalid    = wvalid_q;
      m_axi_bready    = bready_q;
      m_axi_araddr    = addr_q;
      m_axi_arprot    = 3'b000;
      m_axi_arvalid   = arvalid_q;
      m_axi_rready    = rready_q;
   end

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed bench for mem_axi_bridge: a table of single transactions against an
// always-ready slave, then hand-written sequences for stalls, overlapping
// requests and reset mid-transaction.
module tb_mem_axi_bridge;

   logic        clk;
   logic        rstn;
   logic        request_enable;
   logic        req_mode;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        response_enable;
   logic [31:0] resp_data;
   logic        bus_error;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   int n_checks = 0;
   int n_errors = 0;
   int resp_cnt = 0;

   typedef struct {
      logic        mode;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic [1:0]  bresp;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[6];

   mem_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rstn(rstn),
      .request_enable(request_enable), .req_mode(req_mode),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .response_enable(response_enable), .resp_data(resp_data), .bus_error(bus_error),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count completion pulses seen by the MMU side.
   always @(negedge clk) begin
      if (rstn && response_enable) resp_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic slave_ready(input logic [31:0] rdata, input logic [1:0] rresp, input logic [1:0] bresp);
      m_axi_arready = 1'b1;
      m_axi_awready = 1'b1;
      m_axi_wready  = 1'b1;
      m_axi_rvalid  = 1'b1;
      m_axi_bvalid  = 1'b1;
      m_axi_rdata   = rdata;
      m_axi_rresp   = rresp;
      m_axi_bresp   = bresp;
   endtask

   task automatic issue(input logic mode, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      request_enable = 1'b1;
      req_mode       = mode;
      req_addr       = addr;
      req_wdata      = wdata;
      req_wstrb      = wstrb;
   endtask

   // One transaction against a slave that is always ready: response at N+3.
   task automatic run_vector(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      slave_ready(v.rdata, v.rresp, v.bresp);
      issue(v.mode, v.addr, v.wdata, v.wstrb);
      cyc();                                  // N+1
      request_enable = 1'b0;
      if (v.mode) begin
         check({tag, ".awvalid"}, {31'd0, m_axi_awvalid}, 32'd1);
         check({tag, ".wvalid"},  {31'd0, m_axi_wvalid},  32'd1);
         check({tag, ".awaddr"},  m_axi_awaddr, v.addr);
         check({tag, ".wdata"},   m_axi_wdata,  v.wdata);
         check({tag, ".wstrb"},   {28'd0, m_axi_wstrb}, {28'd0, v.wstrb});
      end else begin
         check({tag, ".arvalid"}, {31'd0, m_axi_arvalid}, 32'd1);
         check({tag, ".araddr"},  m_axi_araddr, v.addr);
      end
      cyc();                                  // N+2
      if (v.mode) check({tag, ".bready"}, {31'd0, m_axi_bready}, 32'd1);
      else        check({tag, ".rready"}, {31'd0, m_axi_rready}, 32'd1);
      check({tag, ".resp_early"}, {31'd0, response_enable}, 32'd0);
      cyc();                                  // N+3
      check({tag, ".resp_en"},   {31'd0, response_enable}, 32'd1);
      check({tag, ".resp_data"}, resp_data, v.exp_data);
      check({tag, ".bus_error"}, {31'd0, bus_error}, {31'd0, v.exp_err});
      cyc();                                  // N+4
      check({tag, ".resp_drop"}, {31'd0, response_enable}, 32'd0);
      check({tag, ".err_drop"},  {31'd0, bus_error}, 32'd0);
      check({tag, ".data_hold"}, resp_data, v.exp_data);
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 2'b00, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0000, 2'b10, 2'b00, 32'h0000_0000, 1'b1};
      vecs[2] = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'h3, 32'hFFFF_FFFF, 2'b00, 2'b00, 32'h0000_0000, 1'b0};
      vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hA5A5_5A5A, 2'b01, 2'b00, 32'hA5A5_5A5A, 1'b1};
      vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h8765_4321, 4'h0, 32'h1111_1111, 2'b00, 2'b11, 32'h0000_0000, 1'b1};
      vecs[5] = '{1'b1, 32'h0000_0100, 32'hFFFF_0000, 4'hF, 32'h0,         2'b00, 2'b00, 32'h0000_0000, 1'b0};

      rstn = 1'b0;
      issue(1'b0, 32'h0, 32'h0, 4'h0);
      request_enable = 1'b0;
      slave_ready(32'h0, 2'b00, 2'b00);
      cyc();
      cyc();
      // reset state
      check("rst.arvalid",  {31'd0, m_axi_arvalid}, 32'd0);
      check("rst.awvalid",  {31'd0, m_axi_awvalid}, 32'd0);
      check("rst.wvalid",   {31'd0, m_axi_wvalid},  32'd0);
      check("rst.rready",   {31'd0, m_axi_rready},  32'd0);
      check("rst.bready",   {31'd0, m_axi_bready},  32'd0);
      check("rst.resp_en",  {31'd0, response_enable}, 32'd0);
      check("rst.bus_err",  {31'd0, bus_error}, 32'd0);
      check("rst.resp_data", resp_data, 32'd0);
      check("rst.araddr",   m_axi_araddr, 32'd0);
      check("rst.wdata",    m_axi_wdata,  32'd0);
      check("rst.prot",     {26'd0, m_axi_awprot, m_axi_arprot}, 32'd0);
      rstn = 1'b1;
      cyc();

      for (int i = 0; i < 6; i++) run_vector(vecs[i], i);

      // Read with a 5-cycle AR stall, SLVERR, and a stray request mid-stall.
      slave_ready(32'h0BAD_F00D, 2'b10, 2'b00);
      m_axi_arready = 1'b0;
      issue(1'b0, 32'h4000_0100, 32'h0, 4'h0);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         request_enable = (i == 2);
         req_addr       = 32'h5555_0000;
         check($sformatf("stall.arvalid%0d", i), {31'd0, m_axi_arvalid}, 32'd1);
         check($sformatf("stall.araddr%0d", i),  m_axi_araddr, 32'h4000_0100);
         if (i == 5) m_axi_arready = 1'b1;
      end
      request_enable = 1'b0;
      cyc();
      check("stall.ar_drop", {31'd0, m_axi_arvalid}, 32'd0);
      check("stall.rready",  {31'd0, m_axi_rready},  32'd1);
      cyc();
      check("stall.resp_en",  {31'd0, response_enable}, 32'd1);
      check("stall.bus_err",  {31'd0, bus_error}, 32'd1);
      check("stall.data",     resp_data, 32'h0BAD_F00D);
      cyc();
      check("stall.resp_drop", {31'd0, response_enable}, 32'd0);
      check("stall.err_drop",  {31'd0, bus_error}, 32'd0);

      // Write, W handshakes three cycles before AW.
      slave_ready(32'h0, 2'b00, 2'b00);
      m_axi_awready = 1'b0;
      issue(1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0011);
      cyc();
      request_enable = 1'b0;
      check("wfirst.awvalid", {31'd0, m_axi_awvalid}, 32'd1);
      check("wfirst.wvalid",  {31'd0, m_axi_wvalid},  32'd1);
      for (int i = 2; i <= 4; i++) begin
         cyc();
         check($sformatf("wfirst.wdrop%0d", i),   {31'd0, m_axi_wvalid},  32'd0);
         check($sformatf("wfirst.awhold%0d", i),  {31'd0, m_axi_awvalid}, 32'd1);
         check($sformatf("wfirst.bready%0d", i),  {31'd0, m_axi_bready},  32'd0);
      end
      m_axi_awready = 1'b1;
      cyc();
      check("wfirst.aw_drop", {31'd0, m_axi_awvalid}, 32'd0);
      check("wfirst.bready",  {31'd0, m_axi_bready},  32'd1);
      check("wfirst.resp_early", {31'd0, response_enable}, 32'd0);
      cyc();
      check("wfirst.resp_en", {31'd0, response_enable}, 32'd1);
      check("wfirst.data",    resp_data, 32'd0);
      check("wfirst.bus_err", {31'd0, bus_error}, 32'd0);
      cyc();
      check("wfirst.resp_drop", {31'd0, response_enable}, 32'd0);

      // Write with AW and W together, B delayed two cycles.
      slave_ready(32'h0, 2'b00, 2'b00);
      m_axi_bvalid = 1'b0;
      issue(1'b1, 32'h2000_0040, 32'hCAFE_F00D, 4'hF);
      cyc();
      request_enable = 1'b0;
      cyc();
      check("both.aw_drop", {31'd0, m_axi_awvalid}, 32'd0);
      check("both.w_drop",  {31'd0, m_axi_wvalid},  32'd0);
      check("both.bready",  {31'd0, m_axi_bready},  32'd1);
      cyc();
      check("both.bready_hold", {31'd0, m_axi_bready}, 32'd1);
      check("both.resp_wait",   {31'd0, response_enable}, 32'd0);
      m_axi_bvalid = 1'b1;
      cyc();
      check("both.resp_en", {31'd0, response_enable}, 32'd1);
      check("both.b_drop",  {31'd0, m_axi_bready}, 32'd0);
      cyc();
      check("both.resp_drop", {31'd0, response_enable}, 32'd0);

      // Second request during RD_DATA is ignored.
      slave_ready(32'h1357_9BDF, 2'b00, 2'b00);
      m_axi_rvalid = 1'b0;
      issue(1'b0, 32'h0000_3000, 32'h0, 4'h0);
      cyc();
      request_enable = 1'b0;
      cyc();
      issue(1'b0, 32'h0000_2000, 32'h0, 4'h0);
      cyc();
      request_enable = 1'b0;
      check("ign.arvalid", {31'd0, m_axi_arvalid}, 32'd0);
      check("ign.araddr",  m_axi_araddr, 32'h0000_3000);
      check("ign.rready",  {31'd0, m_axi_rready}, 32'd1);
      cyc();
      check("ign.arvalid2", {31'd0, m_axi_arvalid}, 32'd0);
      m_axi_rvalid = 1'b1;
      cyc();
      check("ign.resp_en", {31'd0, response_enable}, 32'd1);
      check("ign.data",    resp_data, 32'h1357_9BDF);
      cyc();
      check("ign.resp_drop", {31'd0, response_enable}, 32'd0);
      v = '{1'b0, 32'h0000_2000, 32'h0, 4'h0, 32'h2468_ACE0, 2'b00, 2'b00, 32'h2468_ACE0, 1'b0};
      run_vector(v, 10);

      // Reset pulsed while awvalid is high.
      slave_ready(32'h0, 2'b00, 2'b00);
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      issue(1'b1, 32'h0000_7000, 32'h7777_7777, 4'hF);
      cyc();
      request_enable = 1'b0;
      check("arst.awvalid_pre", {31'd0, m_axi_awvalid}, 32'd1);
      #1 rstn = 1'b0;
      #1;
      check("arst.awvalid", {31'd0, m_axi_awvalid}, 32'd0);
      check("arst.wvalid",  {31'd0, m_axi_wvalid},  32'd0);
      check("arst.awaddr",  m_axi_awaddr, 32'd0);
      m_axi_awready = 1'b1;
      m_axi_wready  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("arst.no_resp%0d", i), {31'd0, response_enable}, 32'd0);
         check($sformatf("arst.no_bready%0d", i), {31'd0, m_axi_bready}, 32'd0);
      end
      rstn = 1'b1;
      cyc();
      check("arst.idle_resp", {31'd0, response_enable}, 32'd0);
      v = '{1'b1, 32'h0000_7004, 32'h0F0F_0F0F, 4'b0101, 32'h0, 2'b00, 2'b00, 32'h0000_0000, 1'b0};
      run_vector(v, 11);

      cyc();
      check("resp_pulse_count", resp_cnt, 32'd12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
